mips_multicycle_core: RTL

Parametrised multi-cycle MIPS-subset core with internal instruction memory, a 32-entry register file, a load port and a retire trace. It replaces the fixed seven-instruction top-level harness: the bench preloads any program through the load port, pulses `start`, and checks the retire stream and the halt status. Each instruction runs through FETCH/DECODE/EXEC/WB, with an explicit halt instruction and illegal-instruction detection.

---
 rtl/mips_multicycle_core_if.sv | 27 ++
 rtl/mips_multicycle_core.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core_if.sv
// mips_multicycle_core_if: load port, control/status, retire trace and debug read of the core.
interface mips_multicycle_core_if #(
  parameter int DATA_W = 32,
  parameter int PC_W = 4
);
  logic              load_en;
  logic [PC_W-1:0]   load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic [PC_W-1:0]   pc;
  logic              retire_valid;
  logic [4:0]        retire_rd;
  logic [DATA_W-1:0] retire_data;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output load_en, load_addr, load_data, start, dbg_addr,
    input  busy, halted, illegal, pc, retire_valid, retire_rd, retire_data, dbg_data
  );
  modport slave (
    input  load_en, load_addr, load_data, start, dbg_addr,
    output busy, halted, illegal, pc, retire_valid, retire_rd, retire_data, dbg_data
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-subset core with load port and retire trace.
// Define BRANCH_EN to add beq/bne; without it those opcodes decode as illegal.
module mips_multicycle_core #(
  parameter int DATA_W = 32,
  parameter int IMEM_DEPTH = 16,
  localparam int PC_W = $clog2(IMEM_DEPTH)
) (
  input logic clk,
  input logic rst,
  mips_multicycle_core_if.slave io
);
`ifdef BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, br_pc;
  logic [31:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d, alu;
  logic [4:0] dest_q, dest_d;
  logic taken_q, taken_d, illegal_q, illegal_d;
  logic [DATA_W-1:0] regs [32];
  logic [31:0] imem [IMEM_DEPTH];
  logic [5:0] op, fn;
  logic ctl, is_halt, is_addiu, is_r, is_br, legal, taken;
  int tgt;
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign ctl = state_q == IDLE || state_q == HALT;
  assign is_halt = ir_q == 32'h0000_000C;
  assign is_addiu = op == 6'h09;
  assign is_r = op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
  assign is_br = BR && (op == 6'h04 || op == 6'h05);
  assign legal = is_addiu || is_r || is_br;
  // Branches fall through to zero so they retire with data 0.
  assign alu = is_addiu ? a_q + imm_q : !is_r ? '0 :
               fn == 6'h21 ? a_q + b_q : fn == 6'h23 ? a_q - b_q :
               fn == 6'h24 ? a_q & b_q : fn == 6'h25 ? a_q | b_q :
               DATA_W'($signed(a_q) < $signed(b_q));
  assign taken = is_br && ((a_q == b_q) ^ op[0]);
  // Target wraps modulo the memory depth, including negative offsets.
  assign tgt = (int'(pc_q) + 1 + int'($signed(ir_q[15:0]))) % IMEM_DEPTH;
  assign br_pc = PC_W'(tgt < 0 ? tgt + IMEM_DEPTH : tgt);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    imm_d = imm_q;
    res_d = res_q;
    dest_d = dest_q;
    taken_d = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, HALT: if (io.start) begin
        state_d = FETCH;
        pc_d = '0;
        illegal_d = 1'b0;
      end
      FETCH: begin
        ir_d = imem[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        a_d = regs[ir_q[25:21]];
        b_d = regs[ir_q[20:16]];
        imm_d = DATA_W'($signed(ir_q[15:0]));
        dest_d = is_r ? ir_q[15:11] : is_addiu ? ir_q[20:16] : 5'd0;
        illegal_d = illegal_q || !(is_halt || legal);
        state_d = is_halt || !legal ? HALT : EXEC;
      end
      EXEC: begin
        res_d = alu;
        taken_d = taken;
        state_d = WB;
      end
      WB: begin
        pc_d = taken_q ? br_pc : pc_q + 1'b1;
        state_d = pc_q == PC_W'(IMEM_DEPTH - 1) && !taken_q ? HALT : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      imm_q <= '0;
      res_q <= '0;
      dest_q <= '0;
      taken_q <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      imm_q <= imm_d;
      res_q <= res_d;
      dest_q <= dest_d;
      taken_q <= taken_d;
      illegal_q <= illegal_d;
      if (state_q == WB && dest_q != 5'd0) regs[dest_q] <= res_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && ctl && io.load_en) imem[io.load_addr] <= io.load_data;
  end
  assign io.busy = !ctl;
  assign io.halted = state_q == HALT;
  assign io.illegal = illegal_q;
  assign io.pc = pc_q;
  assign io.retire_valid = state_q == WB;
  assign io.retire_rd = state_q == WB ? dest_q : 5'd0;
  assign io.retire_data = state_q == WB ? res_q : '0;
  assign io.dbg_data = io.dbg_addr == 5'd0 ? '0 : regs[io.dbg_addr];
endmodule
